// File: rtl/mul_pkg.sv
// mul_pkg: FSM state type, counter sizing and handshake reset constants
// shared by mul_seq_unit and the ALU FIFO wrappers.
package mul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CALC = 3'd1,
        ST_DONE = 3'd2
    } mul_state_e;

    localparam mul_state_e MUL_RST_STATE = ST_IDLE;
    localparam logic MUL_IN_READY_RST = 1'b1;
    localparam logic MUL_OUT_VALID_RST = 1'b0;

    function automatic int mul_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul_seq_datapath.sv
// mul_seq_datapath: operand magnitudes, {carry, acc, mult} shift register,
// adder and sign fix. Optional early-exit detect under MUL_EARLY_EXIT_EN.
module mul_seq_datapath
    import mul_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = mul_cnt_width(W)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   a_in,
    input  logic [W-1:0]   b_in,
    input  logic           signed_op,
    input  logic [CW-1:0]  cnt,
    output logic [2*W-1:0] product,
    output logic           rem_zero
);

    logic [W-1:0]   mcand;
    logic [W-1:0]   mult;
    logic [W:0]     acc;
    logic           neg;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [W-1:0]   addend;
    logic [W:0]     sum;
    logic [2*W-1:0] p_next;
    logic [2*W-1:0] p_align;
    logic [CW-1:0]  rsh;

    // p_next is the register pair after this cycle's add and shift;
    // rsh is the number of shifts still owed if we stop now.
    always_comb begin
        a_mag   = (signed_op & a_in[W-1]) ? -a_in : a_in;
        b_mag   = (signed_op & b_in[W-1]) ? -b_in : b_in;
        addend  = mult[0] ? mcand : '0;
        sum     = acc + {1'b0, addend};
        p_next  = {sum, mult[W-1:1]};
        rsh     = CW'(W - 1) - cnt;
        p_align = p_next >> rsh;
        product = neg ? -p_align : p_align;
    end

`ifdef MUL_EARLY_EXIT_EN
    logic [W-1:0] rem_mask;

    assign rem_mask = {W{1'b1}} >> (cnt + CW'(1));
    assign rem_zero = ((mult >> 1) & rem_mask) == '0;
`else
    assign rem_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            mult  <= '0;
            acc   <= '0;
            neg   <= 1'b0;
        end else if (load) begin
            mcand <= a_mag;
            mult  <= b_mag;
            acc   <= '0;
            neg   <= signed_op & (a_in[W-1] ^ b_in[W-1]);
        end else if (step) begin
            acc   <= {1'b0, sum[W:1]};
            mult  <= {sum[0], mult[W-1:1]};
        end
    end

endmodule

// File: rtl/mul_seq_unit.sv
// mul_seq_unit: sequential shift-and-add multiplier with tag and handshakes.
// Define MUL_EARLY_EXIT_EN for data-dependent early termination.
module mul_seq_unit
    import mul_pkg::*;
#(
    parameter int MUL_DATA_SIZE = 8,
    parameter int ID_SIZE       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [MUL_DATA_SIZE-1:0]   a_in,
    input  logic [MUL_DATA_SIZE-1:0]   b_in,
    input  logic                       signed_op,
    input  logic [ID_SIZE-1:0]         id_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*MUL_DATA_SIZE-1:0] result,
    output logic [ID_SIZE-1:0]         id_out,
    output logic                       busy
);

    localparam int W  = MUL_DATA_SIZE;
    localparam int CW = mul_cnt_width(W);

    mul_state_e     state;
    logic [CW-1:0]  cnt;
    logic [ID_SIZE-1:0] id_q;
    logic           load;
    logic           step;
    logic           last;
    logic           rem_zero;
    logic [2*W-1:0] product;

    assign load = (state == ST_IDLE) & in_valid;
    assign step = (state == ST_CALC);
    assign last = (cnt == CW'(W - 1)) | rem_zero;

    mul_seq_datapath #(
        .W  (W),
        .CW (CW)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .a_in      (a_in),
        .b_in      (b_in),
        .signed_op (signed_op),
        .cnt       (cnt),
        .product   (product),
        .rem_zero  (rem_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= MUL_RST_STATE;
            in_ready  <= MUL_IN_READY_RST;
            out_valid <= MUL_OUT_VALID_RST;
            busy      <= 1'b0;
            cnt       <= '0;
            id_q      <= '0;
            id_out    <= '0;
            result    <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state    <= ST_CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        id_q     <= id_in;
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (last) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                        result    <= product;
                        id_out    <= id_q;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// tb_mul_seq_unit: directed and random checks of mul_seq_unit (W=8)
// against an arithmetic reference model.
module tb_mul_seq_unit;

    localparam int W   = 8;
    localparam int IDW = 8;
`ifdef MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           signed_op;
    logic [IDW-1:0] id_in;
    logic           in_valid;
    logic           in_ready;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic [IDW-1:0] id_out;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    mul_seq_unit #(
        .MUL_DATA_SIZE (W),
        .ID_SIZE       (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .signed_op (signed_op),
        .id_in     (id_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .id_out    (id_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
        longint pa;
        longint pb;
        pa = s ? longint'($signed(a)) : longint'(a);
        pb = s ? longint'($signed(b)) : longint'(b);
        return (2*W)'(pa * pb);
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b, input logic s);
        int mag;
        int msb;
        mag = (s && b[W-1]) ? (1 << W) - int'(b) : int'(b);
        msb = 0;
        for (int i = 0; i < W; i++)
            if (((mag >> i) & 1) == 1) msb = i;
        return EARLY ? msb + 1 : W;
    endfunction

    // Accepts one operation with out_ready high, then checks latency,
    // product, tag and the return to IDLE.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic s,
                          input logic [IDW-1:0] id);
        int lat;
        @(negedge clk);
        chk($sformatf("%s.in_ready", tag), 64'(in_ready), 64'd1);
        a_in = a; b_in = b; signed_op = s; id_in = id; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in = W'($urandom);
        b_in = W'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("%s.latency", tag), 64'(lat), 64'(ref_lat(b, s)));
        chk($sformatf("%s.result", tag), 64'(result), 64'(ref_mul(a, b, s)));
        chk($sformatf("%s.id_out", tag), 64'(id_out), 64'(id));
        chk($sformatf("%s.busy", tag), 64'(busy), 64'd1);
        @(posedge clk);
        #1;
        chk($sformatf("%s.released", tag), 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [2*W-1:0] hold_res;
        logic [IDW-1:0] hold_id;
        logic [2*W-1:0] q_res[$];
        logic [IDW-1:0] q_id[$];
        logic [W-1:0]   ra;
        logic [W-1:0]   rb;
        logic           rs;
        int             wait_cnt;
        int             sent;
        int             got;
        int             last_acc;
        int             last_lat;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; signed_op = 1'b0; id_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.out_valid", 64'(out_valid), 64'd0);
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.result", 64'(result), 64'd0);
        chk("reset.id_out", 64'(id_out), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1_ffxff", 8'hFF, 8'hFF, 1'b0, 8'h5A);
        run_op("t2_m128sq", 8'h80, 8'h80, 1'b1, 8'h11);
        run_op("t2_3xm5", 8'h03, 8'hFB, 1'b1, 8'h22);
        run_op("t2_3xfb_u", 8'h03, 8'hFB, 1'b0, 8'h33);

        // Backpressure: DONE holds while in_valid toggles.
        out_ready = 1'b0;
        @(negedge clk);
        a_in = 8'h12; b_in = 8'h34; signed_op = 1'b0;
        id_in = 8'h77; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 40) begin
            @(posedge clk);
            #1;
            wait_cnt++;
        end
        chk("bp.out_valid", 64'(out_valid), 64'd1);
        chk("bp.result", 64'(result), 64'(ref_mul(8'h12, 8'h34, 1'b0)));
        hold_res = result;
        hold_id  = id_out;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            a_in      = W'($urandom);
            b_in      = W'($urandom);
            signed_op = 1'($urandom);
            id_in     = IDW'($urandom);
            @(posedge clk);
            #1;
            chk("bp.hold_result", 64'(result), 64'(hold_res));
            chk("bp.hold_id", 64'(id_out), 64'(hold_id));
            chk("bp.in_ready", 64'(in_ready), 64'd0);
            chk("bp.out_valid_hold", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.drain", 64'(out_valid), 64'd0);
        chk("bp.idle", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        chk("bp.no_second", 64'(busy), 64'd0);

        // Reset in the middle of CALC.
        @(negedge clk);
        a_in = 8'h55; b_in = 8'h66; signed_op = 1'b0;
        id_in = 8'h44; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid.in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid.out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid.result", 64'(result), 64'd0);
        chk("rst_mid.busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("t4_7x9", 8'h07, 8'h09, 1'b0, 8'h3C);

        run_op("t5_b1", 8'h9D, 8'h01, 1'b0, 8'h01);
        run_op("t5_b0", 8'h44, 8'h00, 1'b0, 8'h02);
        run_op("t5_b80", 8'h03, 8'h80, 1'b0, 8'h03);
        run_op("t5_sm1", 8'h7F, 8'hFF, 1'b1, 8'h04);

        // Back-to-back random stream with out_ready held high.
        sent = 0; got = 0; last_acc = 0; last_lat = 0; wait_cnt = 0;
        while (got < 100 && wait_cnt < 3000) begin
            @(negedge clk);
            wait_cnt++;
            if (out_valid) begin
                chk("stream.result", 64'(result), 64'(q_res.pop_front()));
                chk("stream.id_out", 64'(id_out), 64'(q_id.pop_front()));
                got++;
            end
            if (in_ready && sent < 100) begin
                if (sent > 0)
                    chk("stream.spacing", 64'(cyc - last_acc),
                        64'(last_lat + 2));
                ra = W'($urandom);
                rb = W'($urandom);
                rs = 1'($urandom);
                a_in = ra; b_in = rb; signed_op = rs;
                id_in = IDW'(sent); in_valid = 1'b1;
                q_res.push_back(ref_mul(ra, rb, rs));
                q_id.push_back(IDW'(sent));
                last_lat = ref_lat(rb, rs);
                last_acc = cyc;
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("stream.count", 64'(got), 64'd100);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
